// File: rtl/clock_ctrl.sv
// clock_ctrl: run/stop/single-step CPU clock generator with programmable
// divider, halt/break handling and a CPU cycle counter.
// Optional feature macro: CLOCK_CTRL_BRK_EN (honour the brk input).
module clock_ctrl #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             stop_req,
  input  logic             step_req,
  input  logic [DIV_W-1:0] div,
  input  logic             brk,
  input  logic             hlt,
  output logic             cpu_clk,
  output logic             cpu_iclk,
  output logic             ctrlen,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic               cpu_clk_q, cpu_clk_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic               stop_pend_q, stop_pend_d;
  logic               brk_en;
  logic               half_done;

`ifdef CLOCK_CTRL_BRK_EN
  assign brk_en = brk;
`else
  logic unused_brk;
  assign unused_brk = brk;
  assign brk_en     = 1'b0;
`endif

  // end of the current cpu_clk half-period; div is sampled at every compare
  assign half_done = (cnt_q == div);

  // state register and datapath flops, all cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PAUSED;
      cnt_q       <= '0;
      cpu_clk_q   <= 1'b0;
      cycles_q    <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_clk_q   <= cpu_clk_d;
      cycles_q    <= cycles_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // next-state, divider, clock toggle and cycle counting
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cpu_clk_d   = cpu_clk_q;
    cycles_d    = cycles_q;
    stop_pend_d = stop_pend_q;

    unique case (state_q)
      PAUSED: begin
        cnt_d       = '0;
        cpu_clk_d   = 1'b0;
        stop_pend_d = 1'b0;
        if (run_req)       state_d = RUN;
        else if (step_req) state_d = STEP;
      end

      RUN: begin
        // a stop arriving this edge counts as pending immediately, so a
        // low phase pauses without ever producing another rise
        stop_pend_d = stop_pend_q | stop_req;
        if (!cpu_clk_q && stop_pend_d) begin
          state_d     = PAUSED;
          cnt_d       = '0;
          stop_pend_d = 1'b0;
        end else if (half_done) begin
          cnt_d     = '0;
          cpu_clk_d = ~cpu_clk_q;
          if (!cpu_clk_q) begin
            cycles_d = cycles_q + 1'b1;
          end else if (hlt) begin
            state_d     = HALTED;
            stop_pend_d = 1'b0;
          end else if (brk_en || stop_pend_d) begin
            state_d     = PAUSED;
            stop_pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STEP: begin
        if (half_done) begin
          cnt_d     = '0;
          cpu_clk_d = ~cpu_clk_q;
          if (!cpu_clk_q) cycles_d = cycles_q + 1'b1;
          else if (hlt)   state_d  = HALTED;
          else            state_d  = PAUSED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HALTED: begin
        cnt_d       = '0;
        cpu_clk_d   = 1'b0;
        stop_pend_d = 1'b0;
      end

      default: state_d = PAUSED;
    endcase
  end

  assign cpu_clk  = cpu_clk_q;
  assign cpu_iclk = ~cpu_clk_q;
  assign ctrlen   = (state_q != HALTED);
  assign state    = state_q;
  assign cycles   = cycles_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: directed scenarios plus randomized run against a
// cycle-level reference model of the clock controller.
module tb_clock_ctrl;
  localparam int DIV_W = 8;
  localparam int CNT_W = 8;
`ifdef CLOCK_CTRL_BRK_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             run_req = 1'b0, stop_req = 1'b0, step_req = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic             brk = 1'b0, hlt = 1'b0;
  logic             cpu_clk, cpu_iclk, ctrlen;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycles;

  int tests_run = 0;
  int fails     = 0;

  // reference model: state as integer 0..3, elapsed clocks in current half
  int m_state, m_el, m_cyc;
  bit m_clk, m_pend;

  clock_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .stop_req(stop_req),
    .step_req(step_req), .div(div), .brk(brk), .hlt(hlt),
    .cpu_clk(cpu_clk), .cpu_iclk(cpu_iclk), .ctrlen(ctrlen),
    .state(state), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_el = 0; m_cyc = 0; m_clk = 0; m_pend = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    case (m_state)
      0: begin
        if (run_req)       begin m_state = 1; m_el = 0; end
        else if (step_req) begin m_state = 2; m_el = 0; end
        m_pend = 0;
      end
      1, 2: begin
        if (m_state == 1 && stop_req) m_pend = 1;
        if (m_state == 1 && !m_clk && m_pend) begin
          m_state = 0; m_pend = 0;
        end else begin
          m_el++;
          if (m_el == int'(div) + 1) begin
            m_el = 0;
            if (!m_clk) begin
              m_clk = 1;
              m_cyc = (m_cyc + 1) % (1 << CNT_W);
            end else begin
              m_clk = 0;
              if (hlt) m_state = 3;
              else if ((BRK_EN && brk) || m_pend || m_state == 2) m_state = 0;
              if (m_state != 1) m_pend = 0;
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run_req = 0; stop_req = 0; step_req = 0; brk = 0; hlt = 0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run_req = 1'b1; step_req = 1'b1;
    model_reset();
    tick(); tick();
    tests_run++;
    if ({state, cpu_clk, cpu_iclk, ctrlen, cycles} !== {2'd0, 1'b0, 1'b1, 1'b1, 8'd0}) begin
      fails++;
      $display("FAIL reset: state=%0d clk=%b iclk=%b ctrlen=%b cycles=%0d, want 0 0 1 1 0",
               state, cpu_clk, cpu_iclk, ctrlen, cycles);
    end
    run_req = 0; step_req = 0;
    rst = 1'b0;
    tick();
    tests_run++;
    if (state !== 2'd0) begin
      fails++;
      $display("FAIL reset_req_ignored: state=%0d want 0", state);
    end
  endtask

  task automatic test_run_div0();
    do_reset();
    div = 0; run_req = 1; tick(); run_req = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      tests_run++;
      if (cpu_clk !== bit'(k % 2) || cpu_iclk !== ~cpu_clk || state !== 2'd1) begin
        fails++;
        $display("FAIL run_div0 edge %0d: clk=%b iclk=%b state=%0d want clk=%0d state=1",
                 k, cpu_clk, cpu_iclk, state, k % 2);
      end
    end
    tests_run++;
    if (cycles !== 8'd5) begin
      fails++;
      $display("FAIL run_div0_cycles: got %0d want 5", cycles);
    end
    stop_req = 1; tick(); stop_req = 0;
    tests_run++;
    if (state !== 2'd0 || cpu_clk !== 1'b0) begin
      fails++;
      $display("FAIL run_stop_low: state=%0d clk=%b want 0 0", state, cpu_clk);
    end
  endtask

  task automatic test_step();
    do_reset();
    div = 3; step_req = 1; tick(); step_req = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      tests_run++;
      if (cpu_clk !== (k >= 4 && k <= 7) || state !== ((k == 8) ? 2'd0 : 2'd2)) begin
        fails++;
        $display("FAIL step edge %0d: clk=%b state=%0d", k, cpu_clk, state);
      end
    end
    run_req = 0; stop_req = 1; tick(); stop_req = 0;
    tests_run++;
    if (cycles !== 8'd1 || state !== 2'd0) begin
      fails++;
      $display("FAIL step_done: cycles=%0d state=%0d want 1 0", cycles, state);
    end
  endtask

  task automatic test_stop_high();
    do_reset();
    div = 1; run_req = 1; tick(); run_req = 0;
    tick(); tick();
    stop_req = 1; tick(); stop_req = 0;
    tests_run++;
    if (cpu_clk !== 1'b1 || state !== 2'd1) begin
      fails++;
      $display("FAIL stop_high_hold: clk=%b state=%0d want 1 1", cpu_clk, state);
    end
    tick();
    tests_run++;
    if (cpu_clk !== 1'b0 || state !== 2'd0) begin
      fails++;
      $display("FAIL stop_high_pause: clk=%b state=%0d want 0 0", cpu_clk, state);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      tests_run++;
      if (cpu_clk !== 1'b0 || cycles !== 8'd1) begin
        fails++;
        $display("FAIL stop_no_rise: clk=%b cycles=%0d want 0 1", cpu_clk, cycles);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    div = 2; run_req = 1; tick(); run_req = 0;
    for (int k = 1; k <= 4; k++) tick();
    hlt = 1;
    tick();
    tests_run++;
    if (state !== 2'd1 || cpu_clk !== 1'b1) begin
      fails++;
      $display("FAIL halt_wait: state=%0d clk=%b want 1 1", state, cpu_clk);
    end
    tick();
    hlt = 0;
    tests_run++;
    if (state !== 2'd3 || ctrlen !== 1'b0 || cpu_clk !== 1'b0) begin
      fails++;
      $display("FAIL halt_enter: state=%0d ctrlen=%b clk=%b want 3 0 0", state, ctrlen, cpu_clk);
    end
    run_req = 1; step_req = 1; stop_req = 1;
    for (int k = 0; k < 4; k++) tick();
    run_req = 0; step_req = 0; stop_req = 0;
    tests_run++;
    if (state !== 2'd3 || cycles !== 8'd1) begin
      fails++;
      $display("FAIL halt_sticky: state=%0d cycles=%0d want 3 1", state, cycles);
    end
    #2 rst = 1; model_reset();
    #1;
    tests_run++;
    if (state !== 2'd0 || ctrlen !== 1'b1) begin
      fails++;
      $display("FAIL halt_reset: state=%0d ctrlen=%b want 0 1", state, ctrlen);
    end
    tick();
    rst = 0;
  endtask

  task automatic test_brk();
    do_reset();
    div = 1; run_req = 1; tick(); run_req = 0;
    brk = 1;
    for (int k = 1; k <= 4; k++) tick();
    brk = 0;
    tests_run++;
    if (state !== (BRK_EN ? 2'd0 : 2'd1) || cpu_clk !== 1'b0) begin
      fails++;
      $display("FAIL brk: state=%0d clk=%b want %0d 0", state, cpu_clk, BRK_EN ? 0 : 1);
    end
    stop_req = 1; tick(); stop_req = 0;
    tests_run++;
    if (state !== 2'd0) begin
      fails++;
      $display("FAIL brk_stop: state=%0d want 0", state);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    div = 0; run_req = 1; tick(); run_req = 0;
    for (int k = 1; k <= 507; k++) tick();
    tests_run++;
    if (cycles !== 8'hFE) begin
      fails++;
      $display("FAIL wrap_pre: cycles=%0h want fe", cycles);
    end
    for (int k = 508; k <= 513; k++) tick();
    tests_run++;
    if (cycles !== 8'h01 || cpu_clk !== 1'b1) begin
      fails++;
      $display("FAIL wrap: cycles=%0h clk=%b want 01 1", cycles, cpu_clk);
    end
    #1 rst = 1; model_reset();
    #1;
    tests_run++;
    if (cpu_clk !== 1'b0 || cpu_iclk !== 1'b1 || cycles !== 8'd0 || state !== 2'd0) begin
      fails++;
      $display("FAIL reset_mid_high: clk=%b iclk=%b cycles=%0d state=%0d want 0 1 0 0",
               cpu_clk, cpu_iclk, cycles, state);
    end
    tick();
    rst = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      run_req  = ($urandom % 16) == 0;
      stop_req = ($urandom % 12) == 0;
      step_req = ($urandom % 10) == 0;
      brk      = ($urandom % 16) == 0;
      hlt      = ($urandom % 80) == 0;
      if (m_state == 0 && ($urandom % 6) == 0) div = DIV_W'($urandom % 4);
      if (($urandom % 400) == 0) begin
        rst = 1;
        model_reset();
      end else begin
        rst = 0;
      end
      tick();
      tests_run++;
      if (state !== 2'(m_state) || cpu_clk !== m_clk || cpu_iclk !== ~m_clk ||
          ctrlen !== (m_state != 3) || cycles !== CNT_W'(m_cyc)) begin
        fails++;
        $display("FAIL random @%0d: state=%0d clk=%b iclk=%b ctrlen=%b cycles=%0d want %0d %b %b %b %0d",
                 i, state, cpu_clk, cpu_iclk, ctrlen, cycles,
                 m_state, m_clk, ~m_clk, m_state != 3, m_cyc);
      end
    end
    rst = 0; run_req = 0; stop_req = 0; step_req = 0; brk = 0; hlt = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_div0();
    test_step();
    test_stop_high();
    test_halt();
    test_brk();
    test_wrap_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
